shiftr_collect: RTL and testbench

SHIFTR_COLLECT -- requirements
Module: shiftr_collect

---
 rtl/shiftr_pkg.sv | 12 +
 rtl/shiftr_collect.sv | 125 ++++++++++++
 tb/tb_shiftr_collect.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/shiftr_pkg.sv
// Shared definitions for the serial-to-parallel word collector and the
// upstream shifter users: collector state encoding and the default word width.
package shiftr_pkg;

  localparam int SHIFTR_WIDTH = 16;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_PARITY  = 1'b1
  } state_t;

endpackage

// File: rtl/shiftr_collect.sv
// Serial-to-parallel word collector with a single registered output buffer.
// Bits arrive LSB first, one per din_en cycle. A completed word is loaded into
// o. If o is still held (o_valid && !o_ready), the new word is dropped and the
// sticky overflow flag is set.
// Optional feature: define SHIFTR_COLLECT_PARITY_EN to add an even-parity bit
// after each word. That build also adds the PARITY state and the par_err output.
module shiftr_collect
  import shiftr_pkg::*;
#(
  parameter int WIDTH = SHIFTR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_en,
  input  logic             sof,
  output logic [WIDTH-1:0] o,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             overflow,
  input  logic             clr,
`ifdef SHIFTR_COLLECT_PARITY_EN
  output logic             par_err,
`endif
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sr_shift;
  logic [WIDTH-1:0] word;
  logic             last_bit;
  logic             complete;
  logic             ovf_set;

  assign sr_shift = {din, sr_q[WIDTH-1:1]};
  // A plain data bit that fills the last position. sof restarts the word, so
  // that bit never counts as the last bit.
  assign last_bit = din_en && !sof && (state_q == ST_COLLECT) &&
                    (cnt_q == CW'(WIDTH - 1));
  assign ovf_set  = complete && o_valid && !o_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_COLLECT;
    else     state_q <= state_d;
  end

  // Next state: sof always returns to COLLECT; the parity build detours
  // through PARITY for one din_en bit after the data bits.
  always_comb begin
    state_d = state_q;
    if (sof) begin
      state_d = ST_COLLECT;
    end else if (last_bit) begin
`ifdef SHIFTR_COLLECT_PARITY_EN
      state_d = ST_PARITY;
`else
      state_d = ST_COLLECT;
`endif
    end else if (din_en && state_q == ST_PARITY) begin
      state_d = ST_COLLECT;
    end
  end

  // Outputs of the FSM: the completion strobe, the completed word and busy
  always_comb begin
`ifdef SHIFTR_COLLECT_PARITY_EN
    complete = din_en && !sof && (state_q == ST_PARITY);
    word     = sr_q;
`else
    complete = last_bit;
    word     = sr_shift;
`endif
    busy = (cnt_q != '0) || (state_q == ST_PARITY);
  end

  // Shift register and bit counter. sof drops any partial word, and a
  // concurrent din becomes bit 0 of the new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (sof) begin
      sr_q  <= din_en ? {din, {(WIDTH-1){1'b0}}} : '0;
      cnt_q <= din_en ? CW'(1) : '0;
    end else if (din_en && state_q == ST_COLLECT) begin
      sr_q  <= sr_shift;
      cnt_q <= last_bit ? '0 : cnt_q + 1'b1;
    end
  end

  // Single output buffer. A completion that meets a held word is dropped.
  // A completion that meets a transfer replaces the word and keeps o_valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o       <= '0;
      o_valid <= 1'b0;
    end else if (complete && (!o_valid || o_ready)) begin
      o       <= word;
      o_valid <= 1'b1;
    end else if (o_valid && o_ready) begin
      o_valid <= 1'b0;
    end
  end

`ifdef SHIFTR_COLLECT_PARITY_EN
  // Parity status travels with the word it describes
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   par_err <= 1'b0;
    else if (complete && (!o_valid || o_ready)) par_err <= (^sr_q) ^ din;
  end
`endif

  // Sticky overflow flag. A new drop takes priority over clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (clr)     overflow <= 1'b0;
  end

endmodule

// File: tb/tb_shiftr_collect.sv
// Self-checking bench for shiftr_collect (WIDTH=16). Directed scenarios are
// followed by random traffic. A bit-queue reference model predicts every
// output on each cycle.
module tb_shiftr_collect;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         din = 1'b0, din_en = 1'b0, sof = 1'b0, o_ready = 1'b0, clr = 1'b0;
  logic [W-1:0] o;
  logic         o_valid, overflow, busy;
`ifdef SHIFTR_COLLECT_PARITY_EN
  logic         par_err;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  bit           bits[$];
  logic [W-1:0] m_o   = '0;
  logic         m_v   = 1'b0;
  logic         m_ovf = 1'b0;
  logic         m_pe  = 1'b0;

  shiftr_collect #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_en(din_en), .sof(sof),
    .o(o), .o_valid(o_valid), .o_ready(o_ready), .overflow(overflow),
    .clr(clr),
`ifdef SHIFTR_COLLECT_PARITY_EN
    .par_err(par_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".o"},        32'(o),        32'(m_o));
    chk({tag, ".o_valid"},  32'(o_valid),  32'(m_v));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".busy"},     32'(busy),     32'(bits.size() != 0));
`ifdef SHIFTR_COLLECT_PARITY_EN
    chk({tag, ".par_err"},  32'(par_err),  32'(m_pe));
`endif
  endtask

  task automatic model_reset();
    bits.delete();
    m_o = '0; m_v = 1'b0; m_ovf = 1'b0; m_pe = 1'b0;
  endtask

  // Reference: keep received bits in a queue. A word is complete once enough
  // bits are present: W, or W+1 with the trailing parity bit.
  task automatic model_step(input bit d, input bit e, input bit s, input bit r, input bit c);
    bit           comp = 0;
    logic [W-1:0] wd = '0;
    bit           pe = 0;
    int           need;
    bit           set;
`ifdef SHIFTR_COLLECT_PARITY_EN
    need = W + 1;
`else
    need = W;
`endif
    if (s) bits.delete();
    if (e) begin
      bits.push_back(d);
      if (bits.size() == need) begin
        for (int i = 0; i < W; i++) wd[i] = bits[i];
        for (int i = 0; i < need; i++) pe ^= bits[i];
        comp = 1;
        bits.delete();
      end
    end
    set = comp && m_v && !r;
    if (comp && !set) begin
      m_o = wd; m_v = 1'b1; m_pe = pe;
    end else if (m_v && r) begin
      m_v = 1'b0;
    end
    if (set)    m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
  endtask

  // one clock: drive after negedge, model at posedge, check at next negedge
  task automatic cyc(input bit d, input bit e, input bit s, input bit r, input bit c,
                     input string tag);
    din = d; din_en = e; sof = s; o_ready = r; clr = c;
    @(posedge clk);
    model_step(d, e, s, r, c);
    @(negedge clk);
    chk_all(tag);
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit gaps, input bit first_sof,
                           input bit r, input string tag);
    for (int i = 0; i < W; i++) begin
      if (gaps) cyc(1'b0, 1'b0, 1'b0, r, 1'b0, tag);
      cyc(w[i], 1'b1, first_sof && (i == 0), r, 1'b0, tag);
    end
  endtask

  initial begin
    logic [W-1:0] v;
    int           vcnt;
    // reset state
    @(negedge clk);
    chk_all("reset");
    rst = 1'b0;

    // continuous stream, consumer always ready
    send_word(16'hA5C3, 1'b0, 1'b0, 1'b1, "stream");
    chk("stream.word", 32'(o), 32'hA5C3);
    chk("stream.valid", 32'(o_valid), 32'd1);
    cyc(0, 0, 0, 1, 0, "stream.drain");
    chk("stream.one_cycle", 32'(o_valid), 32'd0);

    // din_en gaps cause no shift
    send_word(16'hA5C3, 1'b1, 1'b0, 1'b1, "gaps");
    chk("gaps.word", 32'(o), 32'hA5C3);

    // held output, dropped second word, clr, then transfer
    cyc(0, 0, 0, 1, 0, "hold.pre");
    send_word(16'h1234, 1'b0, 1'b0, 1'b0, "hold1");
    send_word(16'h5678, 1'b0, 1'b0, 1'b0, "hold2");
    chk("hold.o", 32'(o), 32'h1234);
    chk("hold.ovf", 32'(overflow), 32'd1);
    cyc(0, 0, 0, 0, 1, "hold.clr");
    chk("hold.ovf_clr", 32'(overflow), 32'd0);
    cyc(0, 0, 0, 1, 0, "hold.xfer");
    chk("hold.after_xfer", 32'(o_valid), 32'd0);

    // partial word discarded by sof
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "sof.partial");
    send_word(16'hBEEF, 1'b0, 1'b1, 1'b1, "sof.word");
    chk("sof.o", 32'(o), 32'hBEEF);
    cyc(0, 0, 0, 1, 0, "sof.drain");

    // asynchronous reset mid-word
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rst.partial");
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk_all("rst.async");
    #1 rst = 1'b0;
    send_word(16'h00FF, 1'b0, 1'b0, 1'b1, "rst.word");
    chk("rst.o", 32'(o), 32'h00FF);

`ifdef SHIFTR_COLLECT_PARITY_EN
    // parity: data 0x0001 with a wrong parity bit, then with a correct one
    cyc(0, 0, 1, 1, 0, "par.sof");
    send_word(16'h0001, 1'b0, 1'b0, 1'b1, "par.d0");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "par.p0");
    chk("par.err1", 32'(par_err), 32'd1);
    chk("par.o1", 32'(o), 32'h0001);
    send_word(16'h0001, 1'b0, 1'b0, 1'b1, "par.d1");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "par.p1");
    chk("par.err0", 32'(par_err), 32'd0);
    chk("par.o0", 32'(o), 32'h0001);
`endif

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      cyc(1'($urandom), ($urandom_range(3) != 0), ($urandom_range(39) == 0),
          1'($urandom), ($urandom_range(19) == 0), "rand");
    end

    // random whole words with always-ready consumer to confirm data ordering
    cyc(0, 0, 1, 1, 0, "rw.sof");
    vcnt = 0;
    for (int k = 0; k < 8; k++) begin
      v = W'($urandom);
      send_word(v, 1'b0, 1'b0, 1'b1, "rw");
`ifdef SHIFTR_COLLECT_PARITY_EN
      cyc(^v, 1'b1, 1'b0, 1'b1, 1'b0, "rw.par");
`endif
      chk("rw.word", 32'(o), 32'(v));
      vcnt++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
